ahb_input_stage: RTL and testbench

// - Per-manager address-phase buffer between one AHB manager port and the multi-manager arbiter.
// - When the manager's bus grant is high, the manager's address phase passes straight through to the shared bus.
// - When the grant is low, the block captures the address phase and stalls the manager with HREADYOut=0.
// - When a grant arrives, the block replays the captured address phase on the shared bus.
// - Data-phase signals (HWDATA, HWSTRB, HRDATA, HRESP) are routed outside this block.

---
 rtl/ahb_input_stage.sv | 179 +++++++++++++++++
 tb/tb_ahb_input_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_input_stage.sv
// Per-manager AHB address-phase buffer: granted transfers pass straight through, ungranted ones are captured and replayed.
// Latency: 0 cycles when granted; a captured transfer goes out on the first Grant & HREADY cycle, at least 1 cycle after capture.
// Backpressure: the manager is stalled (HREADYOut=0) while a captured transfer waits for grant, and follows HREADY otherwise.
//
// Ports:
//   HCLK, HRESETn             bus clock, synchronous active-low reset
//   H*In                      address phase from the manager
//   HREADYOut                 ready back to the manager
//   Request / Grant           arbiter handshake for this manager
//   HREADY                    shared-bus ready (data-phase completion)
//   H*Out                     address phase driven onto the shared bus

module ahb_input_stage #(
    parameter int PA_BITS = 52
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [PA_BITS-1:0] HADDRIn,
    input  logic [2:0]         HSIZEIn,
    input  logic [2:0]         HBURSTIn,
    input  logic [3:0]         HPROTIn,
    input  logic [1:0]         HTRANSIn,
    input  logic               HWRITEIn,
    input  logic               HMASTLOCKIn,
    output logic               HREADYOut,
    output logic               Request,
    input  logic               Grant,
    input  logic               HREADY,
    output logic [PA_BITS-1:0] HADDROut,
    output logic [2:0]         HSIZEOut,
    output logic [2:0]         HBURSTOut,
    output logic [3:0]         HPROTOut,
    output logic [1:0]         HTRANSOut,
    output logic               HWRITEOut,
    output logic               HMASTLOCKOut
);

    // PASS: nothing buffered. HOLD: captured transfer waiting for grant.
    // DATA: replayed transfer in its bus data phase (manager still stalled
    // on its own data phase until HREADY).
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_HOLD = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    state_t state;

    // Captured address phase.
    logic [PA_BITS-1:0] buf_addr;
    logic [2:0]         buf_size;
    logic [2:0]         buf_burst;
    logic [3:0]         buf_prot;
    logic [1:0]         buf_trans;
    logic               buf_write;
    logic               buf_lock;

    logic holding;
    logic accept;
    logic capture;
    logic bus_take;

    assign holding  = (state == ST_HOLD);
    assign bus_take = Grant & HREADY;

    // The manager only presents a new transfer when it sees ready. In HOLD
    // HREADYOut is 0, so accept (and hence capture) can never fire there,
    // and in DATA with HREADY=0 the same holds.
    assign accept  = HTRANSIn[1] & HREADYOut;
    assign capture = accept & ~bus_take;

    // Output muxing. Everything here is combinational so that a granted
    // pass-through adds no cycles.
    always_comb begin
        HREADYOut    = HREADY;
        Request      = HTRANSIn[1];
        HADDROut     = HADDRIn;
        HSIZEOut     = HSIZEIn;
        HBURSTOut    = HBURSTIn;
        HPROTOut     = HPROTIn;
        HTRANSOut    = HTRANSIn;
        HWRITEOut    = HWRITEIn;
        HMASTLOCKOut = HMASTLOCKIn;

        if (holding) begin
            HREADYOut    = 1'b0;
            Request      = 1'b1;
            HADDROut     = buf_addr;
            HSIZEOut     = buf_size;
            HBURSTOut    = buf_burst;
            HPROTOut     = buf_prot;
            HWRITEOut    = buf_write;
            HMASTLOCKOut = buf_lock;
            // The replay is detached from its burst on the shared bus, so a
            // captured SEQ beat must start a fresh transfer there.
            HTRANSOut    = (buf_trans == TRANS_SEQ) ? TRANS_NONSEQ : buf_trans;
        end

        // Without grant this manager must not put a transfer on the bus.
        if (!Grant) begin
            HTRANSOut    = TRANS_IDLE;
            HMASTLOCKOut = 1'b0;
        end
    end

    // State and buffer.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_PASS;
            buf_addr  <= '0;
            buf_size  <= '0;
            buf_burst <= '0;
            buf_prot  <= '0;
            buf_trans <= '0;
            buf_write <= 1'b0;
            buf_lock  <= 1'b0;
        end else begin
            case (state)
                ST_PASS: begin
                    if (capture) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus_take) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HREADY=1 finishes the replayed data phase; a transfer
                    // offered in that same cycle either passed through
                    // (granted) or gets captured right away.
                    if (HREADY) begin
                        state <= capture ? ST_HOLD : ST_PASS;
                    end
                end
                default: begin
                    state <= ST_PASS;
                end
            endcase

            // capture is only reachable from PASS or a completing DATA cycle,
            // so the buffer stays frozen for the whole of HOLD.
            if (capture) begin
                buf_addr  <= HADDRIn;
                buf_size  <= HSIZEIn;
                buf_burst <= HBURSTIn;
                buf_prot  <= HPROTIn;
                buf_trans <= HTRANSIn;
                buf_write <= HWRITEIn;
                buf_lock  <= HMASTLOCKIn;
            end
        end
    end

    // While a transfer waits, this manager keeps requesting and stays stalled.
    a_hold_outputs: assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (state == ST_HOLD) |-> (Request && !HREADYOut)
    );

    // A waiting transfer must not be disturbed until it is taken by the bus.
    a_hold_stable: assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (state == ST_HOLD && !bus_take) |=>
            $stable({buf_addr, buf_size, buf_burst, buf_prot, buf_trans, buf_write, buf_lock})
    );

    // Only real transfers (NONSEQ/SEQ) ever get buffered.
    a_buf_is_transfer: assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (state == ST_HOLD) |-> buf_trans[1]
    );

endmodule

// File: tb/tb_ahb_input_stage.sv
module tb_ahb_input_stage;

    localparam int PA = 52;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic          HCLK = 1'b0;
    logic          hresetn;
    logic [PA-1:0] haddr_in;
    logic [2:0]    hsize_in;
    logic [2:0]    hburst_in;
    logic [3:0]    hprot_in;
    logic [1:0]    htrans_in;
    logic          hwrite_in;
    logic          hmastlock_in;
    logic          grant;
    logic          hready;

    logic          hready_out;
    logic          request;
    logic [PA-1:0] haddr_out;
    logic [2:0]    hsize_out;
    logic [2:0]    hburst_out;
    logic [3:0]    hprot_out;
    logic [1:0]    htrans_out;
    logic          hwrite_out;
    logic          hmastlock_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    ahb_input_stage #(.PA_BITS(PA)) dut (
        .HCLK         (HCLK),
        .HRESETn      (hresetn),
        .HADDRIn      (haddr_in),
        .HSIZEIn      (hsize_in),
        .HBURSTIn     (hburst_in),
        .HPROTIn      (hprot_in),
        .HTRANSIn     (htrans_in),
        .HWRITEIn     (hwrite_in),
        .HMASTLOCKIn  (hmastlock_in),
        .HREADYOut    (hready_out),
        .Request      (request),
        .Grant        (grant),
        .HREADY       (hready),
        .HADDROut     (haddr_out),
        .HSIZEOut     (hsize_out),
        .HBURSTOut    (hburst_out),
        .HPROTOut     (hprot_out),
        .HTRANSOut    (htrans_out),
        .HWRITEOut    (hwrite_out),
        .HMASTLOCKOut (hmastlock_out)
    );

    // Reference model: at most one transfer can be waiting for the bus.
    typedef struct packed {
        logic [PA-1:0] addr;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          write;
        logic          lock;
    } xfer_t;

    xfer_t pend_q[$];

    logic          exp_ready;
    logic          exp_req;
    logic [PA-1:0] exp_addr;
    logic [2:0]    exp_size;
    logic [2:0]    exp_burst;
    logic [3:0]    exp_prot;
    logic [1:0]    exp_trans;
    logic          exp_write;
    logic          exp_lock;

    // Expected outputs for the current inputs and model contents.
    task automatic predict();
        if (pend_q.size() != 0) begin
            exp_ready = 1'b0;
            exp_req   = 1'b1;
            exp_addr  = pend_q[0].addr;
            exp_size  = pend_q[0].size;
            exp_burst = pend_q[0].burst;
            exp_prot  = pend_q[0].prot;
            exp_write = pend_q[0].write;
            exp_lock  = grant ? pend_q[0].lock : 1'b0;
            // A replay is always a fresh transfer on the shared bus.
            exp_trans = grant ? T_NONSEQ : T_IDLE;
        end else begin
            exp_ready = hready;
            exp_req   = htrans_in[1];
            exp_addr  = haddr_in;
            exp_size  = hsize_in;
            exp_burst = hburst_in;
            exp_prot  = hprot_in;
            exp_write = hwrite_in;
            exp_lock  = grant ? hmastlock_in : 1'b0;
            exp_trans = grant ? htrans_in : T_IDLE;
        end
    endtask

    // One clock: advance the model using the inputs present at the edge.
    task automatic tick();
        xfer_t x;
        @(posedge HCLK);
        if (!hresetn) begin
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            if (grant && hready) pend_q.delete();
        end else if (htrans_in[1] && hready && !grant) begin
            x.addr  = haddr_in;
            x.size  = hsize_in;
            x.burst = hburst_in;
            x.prot  = hprot_in;
            x.write = hwrite_in;
            x.lock  = hmastlock_in;
            pend_q.push_back(x);
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [PA-1:0] a, input logic w,
                         input logic [2:0] b, input logic g, input logic r);
        hresetn      = 1'b1;
        htrans_in    = t;
        haddr_in     = a;
        hwrite_in    = w;
        hburst_in    = b;
        grant        = g;
        hready       = r;
        hsize_in     = 3'd2;
        hprot_in     = 4'h3;
        hmastlock_in = 1'b0;
    endtask

    task automatic test_reset();
        drive(T_NONSEQ, 52'h77, 1'b0, 3'd0, 1'b0, 1'b1);
        hresetn = 1'b0;
        tick();
        tick();
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", hready_out); end
        vectors++; if (request !== 1'b1) begin miscompares++; $display("FAIL reset_request got=%b exp=1", request); end
        vectors++; if (htrans_out !== T_IDLE) begin miscompares++; $display("FAIL reset_trans got=%b exp=00", htrans_out); end
        vectors++; if (dut.buf_addr !== 52'h0) begin miscompares++; $display("FAIL reset_buf got=%h exp=0", dut.buf_addr); end
        grant = 1'b1;
        @(negedge HCLK);
        vectors++; if (htrans_out !== T_NONSEQ) begin miscompares++; $display("FAIL reset_grant_trans got=%b exp=10", htrans_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_pass_through();
        drive(T_NONSEQ, 52'h1000, 1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (haddr_out !== 52'h1000) begin miscompares++; $display("FAIL pt_addr got=%h exp=1000", haddr_out); end
        vectors++; if (htrans_out !== T_NONSEQ) begin miscompares++; $display("FAIL pt_trans got=%b exp=10", htrans_out); end
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL pt_ready got=%b exp=1", hready_out); end
        tick();
        drive(T_BUSY, 52'h1004, 1'b0, 3'd1, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL pt_no_capture got=%b exp=1", hready_out); end
        vectors++; if (htrans_out !== T_BUSY) begin miscompares++; $display("FAIL pt_busy_trans got=%b exp=01", htrans_out); end
        tick();
        drive(T_BUSY, 52'h1008, 1'b0, 3'd1, 1'b0, 1'b1);
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL pt_busy_not_held got=%b exp=1", hready_out); end
        tick();
    endtask

    task automatic test_stall();
        drive(T_NONSEQ, 52'h2000, 1'b1, 3'd0, 1'b0, 1'b1);
        @(negedge HCLK);
        vectors++; if (htrans_out !== T_IDLE) begin miscompares++; $display("FAIL stall_trans0 got=%b exp=00", htrans_out); end
        tick();
        // The block must ignore whatever the stalled manager drives now.
        drive(T_IDLE, 52'hDEAD, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            vectors++; if (hready_out !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, hready_out); end
            vectors++; if (request !== 1'b1) begin miscompares++; $display("FAIL stall_request[%0d] got=%b exp=1", i, request); end
            tick();
        end
        grant = 1'b1;
        @(negedge HCLK);
        vectors++; if (haddr_out !== 52'h2000) begin miscompares++; $display("FAIL stall_addr got=%h exp=2000", haddr_out); end
        vectors++; if (htrans_out !== T_NONSEQ) begin miscompares++; $display("FAIL stall_trans got=%b exp=10", htrans_out); end
        vectors++; if (hwrite_out !== 1'b1) begin miscompares++; $display("FAIL stall_write got=%b exp=1", hwrite_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL stall_done got=%b exp=1", hready_out); end
        tick();
    endtask

    task automatic test_seq_replay();
        drive(T_SEQ, 52'h3004, 1'b0, 3'b011, 1'b0, 1'b1);
        tick();
        grant = 1'b1;
        @(negedge HCLK);
        vectors++; if (htrans_out !== T_NONSEQ) begin miscompares++; $display("FAIL seq_trans got=%b exp=10", htrans_out); end
        vectors++; if (haddr_out !== 52'h3004) begin miscompares++; $display("FAIL seq_addr got=%h exp=3004", haddr_out); end
        vectors++; if (hburst_out !== 3'b011) begin miscompares++; $display("FAIL seq_burst got=%b exp=011", hburst_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_wait_states();
        drive(T_NONSEQ, 52'h5100, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        grant = 1'b1;
        tick();
        drive(T_NONSEQ, 52'h5200, 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            vectors++; if (hready_out !== 1'b0) begin miscompares++; $display("FAIL ws_ready[%0d] got=%b exp=0", i, hready_out); end
            tick();
        end
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL ws_done got=%b exp=1", hready_out); end
        tick();
        drive(T_NONSEQ, 52'h5300, 1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (haddr_out !== 52'h5300) begin miscompares++; $display("FAIL ws_pass_addr got=%h exp=5300", haddr_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL ws_in_pass got=%b exp=1", hready_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(T_NONSEQ, 52'h2100, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        grant = 1'b1;
        tick();
        drive(T_NONSEQ, 52'h4000, 1'b1, 3'd0, 1'b0, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL b2b_complete got=%b exp=1", hready_out); end
        vectors++; if (htrans_out !== T_IDLE) begin miscompares++; $display("FAIL b2b_trans got=%b exp=00", htrans_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b0) begin miscompares++; $display("FAIL b2b_held got=%b exp=0", hready_out); end
        tick();
        grant = 1'b1;
        @(negedge HCLK);
        vectors++; if (haddr_out !== 52'h4000) begin miscompares++; $display("FAIL b2b_addr got=%h exp=4000", haddr_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid_hold();
        drive(T_NONSEQ, 52'h6000, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        hresetn = 1'b0;
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b0) begin miscompares++; $display("FAIL rst_hold_pre got=%b exp=0", hready_out); end
        tick();
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge HCLK);
        vectors++; if (hready_out !== 1'b1) begin miscompares++; $display("FAIL rst_hold_ready got=%b exp=1", hready_out); end
        vectors++; if (request !== 1'b0) begin miscompares++; $display("FAIL rst_hold_request got=%b exp=0", request); end
        vectors++; if (htrans_out !== T_IDLE) begin miscompares++; $display("FAIL rst_hold_trans got=%b exp=00", htrans_out); end
        vectors++; if (dut.buf_addr !== 52'h0) begin miscompares++; $display("FAIL rst_hold_buf got=%h exp=0", dut.buf_addr); end
        grant = 1'b1;
        @(negedge HCLK);
        vectors++; if (htrans_out !== T_IDLE) begin miscompares++; $display("FAIL rst_no_replay got=%b exp=00", htrans_out); end
        vectors++; if (haddr_out !== 52'h0) begin miscompares++; $display("FAIL rst_no_replay_addr got=%h exp=0", haddr_out); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] r64;
        for (int i = 0; i < 800; i++) begin
            r64          = {$urandom(), $urandom()};
            hresetn      = ($urandom_range(0, 39) != 0);
            haddr_in     = r64[PA-1:0];
            hsize_in     = 3'($urandom_range(0, 7));
            hburst_in    = 3'($urandom_range(0, 7));
            hprot_in     = 4'($urandom_range(0, 15));
            htrans_in    = 2'($urandom_range(0, 3));
            hwrite_in    = 1'($urandom_range(0, 1));
            hmastlock_in = 1'($urandom_range(0, 1));
            grant        = 1'($urandom_range(0, 1));
            hready       = ($urandom_range(0, 3) != 0);
            @(negedge HCLK);
            predict();
            vectors++; if (hready_out !== exp_ready) begin miscompares++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, hready_out, exp_ready); end
            vectors++; if (request !== exp_req) begin miscompares++; $display("FAIL rnd_request[%0d] got=%b exp=%b", i, request, exp_req); end
            vectors++; if (htrans_out !== exp_trans) begin miscompares++; $display("FAIL rnd_trans[%0d] got=%b exp=%b", i, htrans_out, exp_trans); end
            vectors++; if (hmastlock_out !== exp_lock) begin miscompares++; $display("FAIL rnd_lock[%0d] got=%b exp=%b", i, hmastlock_out, exp_lock); end
            if (grant) begin
                vectors++; if (haddr_out !== exp_addr) begin miscompares++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, haddr_out, exp_addr); end
                vectors++; if (hsize_out !== exp_size) begin miscompares++; $display("FAIL rnd_size[%0d] got=%h exp=%h", i, hsize_out, exp_size); end
                vectors++; if (hburst_out !== exp_burst) begin miscompares++; $display("FAIL rnd_burst[%0d] got=%h exp=%h", i, hburst_out, exp_burst); end
                vectors++; if (hprot_out !== exp_prot) begin miscompares++; $display("FAIL rnd_prot[%0d] got=%h exp=%h", i, hprot_out, exp_prot); end
                vectors++; if (hwrite_out !== exp_write) begin miscompares++; $display("FAIL rnd_write[%0d] got=%b exp=%b", i, hwrite_out, exp_write); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive(T_IDLE, 52'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        test_reset();
        test_pass_through();
        test_stall();
        test_seq_replay();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
